// File: rtl/circ_seq_queue.sv
// -----------------------------------------------------------------------------
// circ_seq_queue
//
// Circular sample queue feeding one FIR MAC of the equalizer filter bank.
// The incoming sample strobe is decimated by DECIM. Every kept sample is written
// into an internal RAM. Once WINDOW samples are held, each kept sample starts a
// replay of the sliding window (oldest -> newest), one sample per clock.
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   new_smpl    incoming sample, qualified by wrt_smpl
//   wrt_smpl    sample strobe, one strobe per high cycle
//   flush       synchronous clear of all queue state (wins over wrt_smpl)
//   smpl_out    replayed sample, valid while sequencing is high, held otherwise
//   sequencing  high for exactly WINDOW consecutive cycles per replay
//   full        WINDOW samples are held
//   ovr_err     one-cycle pulse: kept sample arrived while a replay was pending
// -----------------------------------------------------------------------------
module circ_seq_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int WINDOW = 1021,
  parameter int DECIM  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] new_smpl,
  input  logic              wrt_smpl,
  input  logic              flush,
  output logic [DATA_W-1:0] smpl_out,
  output logic              sequencing,
  output logic              full,
  output logic              ovr_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int DCW   = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [DCW-1:0]    DEC_LAST = DCW'(DECIM - 1);
  localparam logic [ADDR_W-1:0] WIN_A    = ADDR_W'(WINDOW);
  localparam logic [ADDR_W-1:0] WIN_LAST = ADDR_W'(WINDOW - 1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [DCW-1:0]    ONE_D    = DCW'(1);

  // Keeping WINDOW two below DEPTH guarantees the window being replayed is
  // never overwritten by the samples that arrive during the replay.
  if (WINDOW < 1 || WINDOW > DEPTH - 2) begin : g_bad_window
    $error("circ_seq_queue: WINDOW must lie in 1 .. 2**ADDR_W-2");
  end
  if (DECIM < 1) begin : g_bad_decim
    $error("circ_seq_queue: DECIM must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEQ  = 2'd2
  } state_t;

  logic [DATA_W-1:0] ram [DEPTH];

  state_t            state;
  logic [DCW-1:0]    dec_cnt;
  logic [ADDR_W-1:0] new_ptr;
  logic [ADDR_W-1:0] fill_cnt;
  logic              pending;
  logic [ADDR_W-1:0] rd_ptr_p0;
  logic [ADDR_W-1:0] rd_cnt_p0;

  logic [DATA_W-1:0] smpl_p1;
  logic              vld_p1;
  logic              full_q;
  logic              ovr_q;

  logic              accept;
  logic [ADDR_W-1:0] new_ptr_nxt;
  logic [ADDR_W-1:0] fill_nxt;
  logic [ADDR_W-1:0] win_start;
  logic              rd_en_p0;
  logic              last_rd_p0;
  logic              seq_start;

  // Oldest sample of the window that ends at the most recently written slot.
  function automatic logic [ADDR_W-1:0] window_base(input logic [ADDR_W-1:0] wr_ptr);
    return wr_ptr - WIN_A;
  endfunction

  always_comb begin
    accept      = wrt_smpl && !flush && (dec_cnt == DEC_LAST);
    new_ptr_nxt = accept ? (new_ptr + ONE_A) : new_ptr;
    fill_nxt    = (accept && (fill_cnt != WIN_A)) ? (fill_cnt + ONE_A) : fill_cnt;
    win_start   = window_base(new_ptr_nxt);
    rd_en_p0    = (state == ST_SEQ);
    last_rd_p0  = rd_en_p0 && (rd_cnt_p0 == WIN_LAST);
    seq_start   = accept && (((state == ST_FILL) && (fill_nxt == WIN_A)) ||
                             (state == ST_IDLE));
  end

  // Sample RAM: write-only port, contents are not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      ram[new_ptr] <= new_smpl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      dec_cnt   <= '0;
      new_ptr   <= '0;
      fill_cnt  <= '0;
      pending   <= 1'b0;
      rd_ptr_p0 <= '0;
      rd_cnt_p0 <= '0;
      smpl_p1   <= '0;
      vld_p1    <= 1'b0;
      full_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else if (flush) begin
      // smpl_p1 deliberately keeps its last value.
      state     <= ST_FILL;
      dec_cnt   <= '0;
      new_ptr   <= '0;
      fill_cnt  <= '0;
      pending   <= 1'b0;
      rd_ptr_p0 <= '0;
      rd_cnt_p0 <= '0;
      vld_p1    <= 1'b0;
      full_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      if (wrt_smpl) begin
        dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : (dec_cnt + ONE_D);
      end
      new_ptr  <= new_ptr_nxt;
      fill_cnt <= fill_nxt;
      full_q   <= (fill_nxt == WIN_A);
      ovr_q    <= accept && (state == ST_SEQ) && pending;

      // ---- p0 -> p1: registered RAM read of the replay address ----
      vld_p1 <= rd_en_p0;
      if (rd_en_p0) begin
        smpl_p1 <= ram[rd_ptr_p0];
      end

      case (state)
        ST_FILL, ST_IDLE: begin
          if (seq_start) begin
            state     <= ST_SEQ;
            rd_ptr_p0 <= win_start;
            rd_cnt_p0 <= '0;
          end
        end
        ST_SEQ: begin
          if (last_rd_p0) begin
            // A sample kept on the last read edge counts as pending too, so
            // the next replay follows with no gap.
            if (pending || accept) begin
              rd_ptr_p0 <= win_start;
              rd_cnt_p0 <= '0;
            end else begin
              state <= ST_IDLE;
            end
            pending <= 1'b0;
          end else begin
            rd_ptr_p0 <= rd_ptr_p0 + ONE_A;
            rd_cnt_p0 <= rd_cnt_p0 + ONE_A;
            if (accept) begin
              pending <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

  assign smpl_out   = smpl_p1;
  assign sequencing = vld_p1;
  assign full       = full_q;
  assign ovr_err    = ovr_q;

endmodule
